mips_data_mem_responder: RTL and testbench
==========================================

// Module: mips_data_mem_responder
// PURPOSE
//  Responder end of the core data-memory interface: accepts word requests from mips_core
//  (mem_addr, mem_data_in, mem_write_en) and returns read bytes on mem_data_out.
//  Byte-addressed storage; fixed, parameterised access latency; req/ready handshake lets the core stall.
//  Sits beside mips_core in the top level; the instruction port is out of scope.
// PARAMETERS
//  XLEN       32    address width
//  MEM_BYTES  8192  storage size in bytes; power of two, >= 4
//  LATENCY    2     cycles from request acceptance to mem_ready pulse; legal range 1..15
// PORTS
//  clk           in   1        single clock, all state updates on rising edge
//  rst_b         in   1        reset, synchronous, active-high
//  mem_req       in   1        core request valid; held high until mem_ready
//  mem_addr      in   XLEN     byte address of lane 0
//  mem_write_en  in   1        1 = write, 0 = read; sampled with mem_req
//  mem_data_in   in   8 x4     write bytes, [0:3], lane i -> byte mem_addr+i
//  mem_data_out  out  8 x4     read bytes, [0:3], lane i <- byte mem_addr+i
//  mem_ready     out  1        one-cycle completion pulse
//  mem_err       out  1        one-cycle error pulse (MEM_ALIGN_CHECK_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: mem_ready=0, mem_err=0, mem_data_out all lanes 8'h00, FSM=IDLE, counter=0; storage not cleared.
//  - FSM IDLE -> WAIT when mem_req=1: latch addr, write_en, data; counter=LATENCY-1.
//    WAIT: decrement each cycle; at 0 -> DONE. LATENCY=1 goes IDLE -> DONE directly.
//    DONE (one cycle): mem_ready=1; write commits all 4 bytes, or read loads mem_data_out; -> IDLE.
//  - Total: request seen in cycle N -> mem_ready high in cycle N+LATENCY.
//  - Back-to-back requests: a request is never accepted in DONE; mem_req still high in the
//    following IDLE cycle is a new request. Throughput is 1 access per LATENCY+1 cycles.
//  - Inputs are sampled only at acceptance; changes during WAIT/DONE are ignored.
//  - mem_data_out holds the last read result until the next read completes; writes do not change it.
//  - Address wrap: byte index = (mem_addr + i) mod MEM_BYTES per lane; upper address bits ignored.
//    A word at MEM_BYTES-2 wraps lanes 2,3 to bytes 0,1.
//  - Read of a word completing in the cycle after a write to the same bytes returns the new data.
//  - Reset mid-operation (WAIT or DONE): the access is aborted, no write commits, no ready pulse.
//  - mem_write_en=1 with mem_req=0 has no effect.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: at acceptance, mem_addr[1:0]!=0 -> IDLE -> DONE path skipped;
//    mem_err and mem_ready both pulse after LATENCY cycles; no write, mem_data_out unchanged.
//  MEM_ALIGN_CHECK_EN undefined: any address accepted, unaligned access uses the wrap rule; mem_err=0.
// STRUCTURE
//  Package mips_mem_pkg: state enum {IDLE, WAIT, DONE}, byte_t (logic [7:0]), word_bytes_t (byte_t [0:3]),
//    MEM_LAT_W counter width constant.
//  Sub-module mem_byte_array: MEM_BYTES x 8 storage, 4 byte-lane ports, common write enable.
//  Top holds FSM, latency counter, request latches, output registers.
// TESTING
//  1 Write addr 0x10 bytes {DE,AD,BE,EF}, then read 0x10 -> mem_data_out {DE,AD,BE,EF}; ready at N+2.
//  2 LATENCY=1: req held high for 3 accesses -> ready pulses every 2nd cycle, never 2 cycles in a row.
//  3 Write 0x11223344 bytes at MEM_BYTES-2, read 0x0 -> lanes 0,1 = {33,44} (wrap).
//  4 rst_b high in WAIT after write to 0x20 -> no ready; later read 0x20 returns pre-write contents.
//  5 MEM_ALIGN_CHECK_EN: write to 0x21 -> mem_err=mem_ready=1 at N+LATENCY; read 0x20 unchanged.
//  6 Write then read, confirm mem_data_out unchanged by write and held between reads.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_mem_pkg;

  localparam int unsigned MEM_LAT_W = 4;
  localparam int unsigned LANES     = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_bytes_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter preload so that DONE is reached exactly LATENCY cycles after acceptance.
  function automatic logic [MEM_LAT_W-1:0] lat_preload(input int unsigned lat);
    return MEM_LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four lane ports sharing one write enable.
module mem_byte_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned IDX_W     = $clog2(MEM_BYTES)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [LANES-1:0][IDX_W-1:0] lane_idx,
  input  word_bytes_t                 wdata,
  output word_bytes_t                 rdata
);

  byte_t mem [MEM_BYTES];

  // Lane indices are always distinct (consecutive mod MEM_BYTES), so no write collisions.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        mem[lane_idx[i]] <= wdata[i];
      end
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_rd
    assign rdata[g] = mem[lane_idx[g]];
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for mips_core: fixed-latency req/ready word access to byte storage.
// Optional MEM_ALIGN_CHECK_EN: unaligned requests complete with mem_err instead of accessing memory.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            mem_req,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mem_write_en,
  input  word_bytes_t     mem_data_in,
  output word_bytes_t     mem_data_out,
  output logic            mem_ready,
  output logic            mem_err
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);

  state_t                 state;
  logic [MEM_LAT_W-1:0]   cnt;
  logic [IDX_W-1:0]       addr_q;
  logic                   we_q;
  word_bytes_t            wdata_q;
  logic                   err_q;

  logic                        acc_err_c;
  logic                        enter_done_c;
  logic                        done_err_c;
  logic                        done_we_c;
  logic                        commit_c;
  logic [IDX_W-1:0]            base_idx_c;
  logic [LANES-1:0][IDX_W-1:0] lane_idx_c;
  word_bytes_t                 rdata_c;
  logic                        unused_addr_c;

  // Storage only sees the low index bits; upper address bits wrap away.
  assign unused_addr_c = ^mem_addr[XLEN-1:IDX_W];

`ifdef MEM_ALIGN_CHECK_EN
  assign acc_err_c = |mem_addr[1:0];
`else
  assign acc_err_c = 1'b0;
`endif

  // With LATENCY=1 the read happens on the acceptance edge, so index from the live address.
  assign base_idx_c = (state == IDLE) ? mem_addr[IDX_W-1:0] : addr_q;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_idx
    assign lane_idx_c[g] = base_idx_c + IDX_W'(g);
  end

  always_comb begin
    enter_done_c = 1'b0;
    done_err_c   = err_q;
    done_we_c    = we_q;
    if (state == IDLE) begin
      enter_done_c = mem_req && (LATENCY == 1);
      done_err_c   = acc_err_c;
      done_we_c    = mem_write_en;
    end else if (state == WAIT) begin
      enter_done_c = (cnt == MEM_LAT_W'(1));
    end
  end

  // Write commits on the edge leaving DONE; a reset in DONE still aborts it.
  assign commit_c = (state == DONE) && we_q && !err_q && !rst_b;

  mem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk      (clk),
    .we       (commit_c),
    .lane_idx (lane_idx_c),
    .wdata    (wdata_q),
    .rdata    (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      mem_ready    <= 1'b0;
      mem_err      <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      if (enter_done_c) begin
        mem_ready <= 1'b1;
        mem_err   <= done_err_c;
        if (!done_we_c && !done_err_c) begin
          mem_data_out <= rdata_c;
        end
      end
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr[IDX_W-1:0];
            we_q    <= mem_write_en;
            wdata_q <= mem_data_in;
            err_q   <= acc_err_c;
            cnt     <= lat_preload(LATENCY);
            state   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - MEM_LAT_W'(1);
          if (enter_done_c) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed self-checking bench for mips_data_mem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_mips_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int unsigned MEM_BYTES = 8192;
  localparam int          TIMEOUT   = 40;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req;
  logic        req1;
  logic [31:0] addr;
  logic        we;
  word_bytes_t din;
  word_bytes_t dout;
  word_bytes_t dout1;
  logic        rdy;
  logic        rdy1;
  logic        err;
  logic        err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_data_mem_responder #(.XLEN(32), .MEM_BYTES(MEM_BYTES), .LATENCY(2)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(req), .mem_addr(addr), .mem_write_en(we),
    .mem_data_in(din), .mem_data_out(dout), .mem_ready(rdy), .mem_err(err)
  );

  mips_data_mem_responder #(.XLEN(32), .MEM_BYTES(MEM_BYTES), .LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .mem_req(req1), .mem_addr(addr), .mem_write_en(we),
    .mem_data_in(din), .mem_data_out(dout1), .mem_ready(rdy1), .mem_err(err1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on the LATENCY=2 instance and return to IDLE afterwards.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output int lat, output logic err_seen);
    req = 1'b1; addr = a; we = w; din = d; lat = 0; err_seen = 1'b0;
    while (!rdy && lat < TIMEOUT) begin
      cycle();
      lat++;
    end
    err_seen = err;
    req = 1'b0; we = 1'b0;
    if (lat >= TIMEOUT) begin
      errors++;
      $display("FAIL timeout addr=%h: no mem_ready within %0d cycles", a, TIMEOUT);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_b = 1'b1; req = 1'b0; req1 = 1'b0; addr = '0; we = 1'b0; din = '0;
    repeat (3) cycle();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=00000000", dout); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", rdy1); end
    rst_b = 1'b0;
    cycle();
  endtask

  task automatic test_write_read();
    int lat; logic e;
    access(32'h10, 1'b1, 32'hDEADBEEF, lat, e);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL wr_pulse_width got=%b exp=0", rdy); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL wr_dout_unchanged got=%h exp=00000000", dout); end
    access(32'h10, 1'b0, 32'h0, lat, e);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", dout); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", e); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] expv;
    expv = 7'b1010100;
    addr = 32'h10; we = 1'b0; din = '0;
    req1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) req1 = 1'b0;
      cycle();
      checks++;
      if (rdy1 !== expv[6-k]) begin
        errors++;
        $display("FAIL b2b_ready sample=%0d got=%b exp=%b", k + 1, rdy1, expv[6-k]);
      end
    end
    req1 = 1'b0;
  endtask

  task automatic test_wrap();
    int lat; logic e;
    access(32'(MEM_BYTES - 2), 1'b1, 32'h11223344, lat, e);
    access(32'h0, 1'b0, 32'h0, lat, e);
    checks++; if (dout[0] !== 8'h33) begin errors++; $display("FAIL wrap_lane0 got=%h exp=33", dout[0]); end
    checks++; if (dout[1] !== 8'h44) begin errors++; $display("FAIL wrap_lane1 got=%h exp=44", dout[1]); end
    access(32'(MEM_BYTES - 2), 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'h11223344) begin errors++; $display("FAIL wrap_word got=%h exp=11223344", dout); end
    access(32'hFFFFE010, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL upper_bits got=%h exp=deadbeef", dout); end
  endtask

  task automatic test_reset_mid();
    int lat; logic e; int seen;
    access(32'h20, 1'b1, 32'hA1B2C3D4, lat, e);
    req = 1'b1; addr = 32'h20; we = 1'b1; din = 32'h55667788;
    cycle();
    rst_b = 1'b1; req = 1'b0; we = 1'b0;
    cycle();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", rdy); end
    rst_b = 1'b0;
    seen = 0;
    repeat (4) begin cycle(); if (rdy !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_late_ready got=%0d pulses exp=0", seen); end
    access(32'h20, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hA1B2C3D4) begin errors++; $display("FAIL rstmid_no_commit got=%h exp=a1b2c3d4", dout); end
  endtask

  task automatic test_align();
    int lat; logic e;
`ifdef MEM_ALIGN_CHECK_EN
    access(32'h21, 1'b1, 32'hFFFFFFFF, lat, e);
    checks++; if (lat != 2) begin errors++; $display("FAIL align_latency got=%0d exp=2", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL align_err got=%b exp=1", e); end
    checks++; if (dout !== 32'hA1B2C3D4) begin errors++; $display("FAIL align_dout got=%h exp=a1b2c3d4", dout); end
    access(32'h20, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hA1B2C3D4) begin errors++; $display("FAIL align_no_write got=%h exp=a1b2c3d4", dout); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL align_rd_err got=%b exp=0", e); end
`else
    access(32'h21, 1'b1, 32'h01020304, lat, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL unaligned_err got=%b exp=0", e); end
    access(32'h20, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hA1010203) begin errors++; $display("FAIL unaligned_rd got=%h exp=a1010203", dout); end
    access(32'h24, 1'b0, 32'h0, lat, e);
    checks++; if (dout[0] !== 8'h04) begin errors++; $display("FAIL unaligned_lane3 got=%h exp=04", dout[0]); end
`endif
  endtask

  task automatic test_hold();
    int lat; logic e; int seen;
    access(32'h10, 1'b0, 32'h0, lat, e);
    access(32'h30, 1'b1, 32'h12345678, lat, e);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_after_wr got=%h exp=deadbeef", dout); end
    req = 1'b0; we = 1'b1; addr = 32'h10; din = 32'h0;
    seen = 0;
    repeat (4) begin cycle(); if (rdy !== 1'b0) seen++; end
    we = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL we_no_req_ready got=%0d pulses exp=0", seen); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_idle got=%h exp=deadbeef", dout); end
    access(32'h10, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL we_no_req_data got=%h exp=deadbeef", dout); end
    access(32'h30, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL raw_read got=%h exp=12345678", dout); end
  endtask

  task automatic test_input_ignore();
    int lat; logic e;
    req = 1'b1; addr = 32'h40; we = 1'b1; din = 32'hCAFEF00D;
    cycle();
    addr = 32'h44; din = 32'h0; we = 1'b0;
    lat = 1;
    while (!rdy && lat < TIMEOUT) begin cycle(); lat++; end
    req = 1'b0;
    checks++; if (lat != 2) begin errors++; $display("FAIL ignore_latency got=%0d exp=2", lat); end
    cycle();
    access(32'h40, 1'b0, 32'h0, lat, e);
    checks++; if (dout !== 32'hCAFEF00D) begin errors++; $display("FAIL ignore_data got=%h exp=cafef00d", dout); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_align();
    test_hold();
    test_input_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
